parser_conf_loader: RTL and testbench



---
 rtl/parser_conf_loader.sv | 217 +++++++++++++++++++++
 tb/tb_parser_conf_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_conf_loader.sv
`default_nettype none
// ============================================================================
// Module   : parser_conf_loader
// Purpose  : Replays a table of (rule_addr, rule_wdata) entries onto the
//            Parser_Top rule bus and holds off PHV injection while it runs.
//            Optional read-back verification is enabled by defining the
//            macro RULE_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module parser_conf_loader #(
  parameter int DEPTH      = 64,
  parameter int GAP        = 0,
  parameter int RD_TIMEOUT = 16,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tbl_wren,
  input  logic [IDX_W-1:0] i_tbl_idx,
  input  logic [31:0]      i_tbl_addr,
  input  logic [31:0]      i_tbl_wdata,
  input  logic [IDX_W:0]   i_tbl_len,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [IDX_W-1:0] o_err_idx,
  output logic             o_hold,
  output logic             o_rule_wren,
  output logic             o_rule_rden,
  output logic [31:0]      o_rule_addr,
  output logic [31:0]      o_rule_wdata,
  input  logic             i_rule_rdata_valid,
  input  logic [31:0]      i_rule_rdata
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_WRITE   = 3'd1;
  localparam logic [2:0] c_ST_GAP     = 3'd2;
`ifdef RULE_READBACK_EN
  localparam logic [2:0] c_ST_RD      = 3'd3;
  localparam logic [2:0] c_ST_WAIT_RD = 3'd4;
`endif
  localparam logic [2:0] c_ST_DONE    = 3'd5;

  localparam logic [3:0]   c_GAP_LAST = (GAP > 0) ? (GAP[3:0] - 4'd1) : 4'd0;
  localparam logic [IDX_W:0] c_DEPTH  = DEPTH[IDX_W:0];

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [63:0]      tbl_q [DEPTH];

  logic             w_busy;
  logic             w_last;
  logic [IDX_W:0]   w_len_start;
  logic [2:0]       w_after_xfer;
  logic [31:0]      w_entry_addr;
  logic [31:0]      w_entry_wdata;

  assign w_busy        = (state_q != c_ST_IDLE) && (state_q != c_ST_DONE);
  assign w_last        = ({1'b0, idx_q} == (len_q - 1'b1));
  assign w_len_start   = (i_tbl_len > c_DEPTH) ? c_DEPTH : i_tbl_len;
  assign w_entry_addr  = tbl_q[idx_q][63:32];
  assign w_entry_wdata = tbl_q[idx_q][31:0];

  // Where to go once an entry is fully handled: the gap only separates
  // writes, so the final entry goes straight to DONE.
  assign w_after_xfer  = w_last ? c_ST_DONE : ((GAP > 0) ? c_ST_GAP : c_ST_WRITE);

  // Table storage: accepts writes only while idle and survives reset
  always_ff @(posedge i_clk) begin
    if (i_tbl_wren && !w_busy) begin
      tbl_q[i_tbl_idx] <= {i_tbl_addr, i_tbl_wdata};
    end
  end

`ifdef RULE_READBACK_EN
  localparam int               c_TMO_W      = $clog2(RD_TIMEOUT + 1);
  localparam int               c_TMO_LAST_I = RD_TIMEOUT - 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_LAST_I[c_TMO_W-1:0];

  logic [c_TMO_W-1:0] tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic               w_tmo;
  logic               w_mismatch;

  assign w_tmo      = (state_q == c_ST_WAIT_RD) && !i_rule_rdata_valid && (tmo_q == c_TMO_LAST);
  assign w_mismatch = w_tmo || (i_rule_rdata_valid && (i_rule_rdata != w_entry_wdata));

  // Read-back bookkeeping: wait timer and sticky first-error capture
  always_comb begin
    err_d     = err_q;
    err_idx_d = err_idx_q;
    tmo_d     = (state_q == c_ST_WAIT_RD) ? (tmo_q + 1'b1) : '0;
    if ((state_q == c_ST_IDLE) && i_start) begin
      err_d     = 1'b0;
      err_idx_d = '0;
    end else if ((state_q == c_ST_WAIT_RD) && w_mismatch && !err_q) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end
  end

  // Read-back registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^{i_rule_rdata_valid, i_rule_rdata};
`endif

  // State and sequencing registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= c_ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state and index/length/gap sequencing
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_cnt_d = (state_q == c_ST_GAP) ? (gap_cnt_q + 4'd1) : 4'd0;
    case (state_q)
      c_ST_IDLE: begin
        if (i_start) begin
          len_d   = w_len_start;
          idx_d   = '0;
          state_d = (w_len_start == '0) ? c_ST_DONE : c_ST_WRITE;
        end
      end
      c_ST_WRITE: begin
`ifdef RULE_READBACK_EN
        state_d = c_ST_RD;
`else
        state_d = w_after_xfer;
`endif
      end
      c_ST_GAP: begin
        if (gap_cnt_q == c_GAP_LAST) begin
          state_d = c_ST_WRITE;
        end
      end
`ifdef RULE_READBACK_EN
      c_ST_RD: begin
        state_d = c_ST_WAIT_RD;
      end
      c_ST_WAIT_RD: begin
        if (i_rule_rdata_valid || w_tmo) begin
          state_d = w_after_xfer;
        end
      end
`endif
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
    // Every re-entry into WRITE from inside a replay moves to the next entry
    if ((state_q != c_ST_IDLE) && (state_d == c_ST_WRITE)) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Outputs; bus strobes are masked while reset is held so a reset cycle
  // never carries a partial rule access
  always_comb begin
    o_busy       = w_busy;
    o_hold       = w_busy;
    o_done       = (state_q == c_ST_DONE);
    o_rule_wren  = i_rst_n && (state_q == c_ST_WRITE);
    o_rule_rden  = 1'b0;
    o_rule_addr  = 32'd0;
    o_rule_wdata = 32'd0;
    o_err        = 1'b0;
    o_err_idx    = '0;
`ifdef RULE_READBACK_EN
    o_rule_rden  = i_rst_n && (state_q == c_ST_RD);
    o_err        = err_q;
    o_err_idx    = err_idx_q;
    if (i_rst_n && ((state_q == c_ST_WRITE) || (state_q == c_ST_RD))) begin
      o_rule_addr  = w_entry_addr;
      o_rule_wdata = w_entry_wdata;
    end
`else
    if (i_rst_n && (state_q == c_ST_WRITE)) begin
      o_rule_addr  = w_entry_addr;
      o_rule_wdata = w_entry_wdata;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_parser_conf_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_parser_conf_loader
// Purpose  : Directed self-checking bench for parser_conf_loader. dut0 uses
//            GAP=0, dut2 uses GAP=2; read-back scenarios run when
//            RULE_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parser_conf_loader;

  logic        clk;
  logic        rst_n;
  logic        tbl_wren0, tbl_wren2;
  logic [5:0]  tbl_idx;
  logic [31:0] tbl_addr, tbl_wdata;
  logic [6:0]  tbl_len;
  logic        start0, start2;
  logic        rvalid0, rvalid2;
  logic [31:0] rdata0, rdata2;

  logic        busy0, done0, err0, hold0, wren0, rden0;
  logic [5:0]  erridx0;
  logic [31:0] addr0, wdata0;
  logic        busy2, done2, err2, hold2, wren2, rden2;
  logic [5:0]  erridx2;
  logic [31:0] addr2, wdata2;

  logic [31:0] ea [64];
  logic [31:0] ed [64];

  int errors = 0;
  int checks = 0;

  parser_conf_loader #(.DEPTH(64), .GAP(0), .RD_TIMEOUT(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tbl_wren(tbl_wren0), .i_tbl_idx(tbl_idx), .i_tbl_addr(tbl_addr),
    .i_tbl_wdata(tbl_wdata), .i_tbl_len(tbl_len), .i_start(start0),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .o_err_idx(erridx0),
    .o_hold(hold0), .o_rule_wren(wren0), .o_rule_rden(rden0),
    .o_rule_addr(addr0), .o_rule_wdata(wdata0),
    .i_rule_rdata_valid(rvalid0), .i_rule_rdata(rdata0)
  );

  parser_conf_loader #(.DEPTH(64), .GAP(2), .RD_TIMEOUT(16)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tbl_wren(tbl_wren2), .i_tbl_idx(tbl_idx), .i_tbl_addr(tbl_addr),
    .i_tbl_wdata(tbl_wdata), .i_tbl_len(tbl_len), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_err_idx(erridx2),
    .o_hold(hold2), .o_rule_wren(wren2), .o_rule_rden(rden2),
    .o_rule_addr(addr2), .o_rule_wdata(wdata2),
    .i_rule_rdata_valid(rvalid2), .i_rule_rdata(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy0 || busy2 || done0 || done2) && (n < 2000)) begin
      step();
      n++;
    end
    chk(tag, 96'(n < 2000), 96'(1));
    step();
  endtask

  initial begin
    int cnt, done_cyc, pend, wr_k;
    logic [31:0] last_addr, pdata;
    logic w0, w2;

    rst_n = 1'b0; tbl_wren0 = 1'b0; tbl_wren2 = 1'b0; tbl_idx = '0;
    tbl_addr = '0; tbl_wdata = '0; tbl_len = '0; start0 = 1'b0; start2 = 1'b0;
    rvalid0 = 1'b0; rvalid2 = 1'b0; rdata0 = '0; rdata2 = '0;
    for (int i = 0; i < 64; i++) begin
      ea[i] = 32'h1000 + 32'(i);
      ed[i] = 32'(i) * 32'd3 + 32'd100;
    end
    ea[0] = 32'h0200; ed[0] = 32'd12;
    ea[1] = 32'h0201; ed[1] = 32'd13;
    ea[2] = 32'h0400; ed[2] = 32'd7;

    // Reset state
    step(); step();
    chk("reset_dut0", 96'({busy0, hold0, done0, err0, erridx0, wren0, rden0, addr0, wdata0}), 96'(0));
    chk("reset_dut2", 96'({busy2, hold2, done2, err2, erridx2, wren2, rden2, addr2, wdata2}), 96'(0));
    rst_n = 1'b1;
    step();

    // Load the full table into both instances
    for (int i = 0; i < 64; i++) begin
      tbl_wren0 = 1'b1; tbl_wren2 = 1'b1; tbl_idx = 6'(i);
      tbl_addr = ea[i]; tbl_wdata = ed[i];
      step();
    end
    tbl_wren0 = 1'b0; tbl_wren2 = 1'b0;

`ifndef RULE_READBACK_EN
    // Three-entry replay, GAP=0 and GAP=2; extra starts while busy / on done are ignored
    tbl_len = 7'd3; start0 = 1'b1; start2 = 1'b1;
    step();
    start0 = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      w0 = (c <= 3);
      w2 = (c == 1) || (c == 4) || (c == 7);
      chk($sformatf("t1_g0_ctl_c%0d", c), 96'({busy0, hold0, done0, wren0, rden0, err0}),
          96'({w0, w0, (c == 4), w0, 1'b0, 1'b0}));
      chk($sformatf("t1_g0_bus_c%0d", c), 96'({addr0, wdata0}),
          w0 ? 96'({ea[c-1], ed[c-1]}) : 96'(0));
      chk($sformatf("t1_g2_ctl_c%0d", c), 96'({busy2, hold2, done2, wren2, rden2, err2}),
          96'({(c <= 7), (c <= 7), (c == 8), w2, 1'b0, 1'b0}));
      chk($sformatf("t1_g2_bus_c%0d", c), 96'({addr2, wdata2}),
          w2 ? 96'({ea[(c-1)/3], ed[(c-1)/3]}) : 96'(0));
      start0 = (c == 2) || (c == 4);
      start2 = (c == 2) || (c == 4);
      step();
    end
    start0 = 1'b0; start2 = 1'b0;
    wait_idle("t1_idle");
`endif

    // Zero-length replay, start on the done cycle ignored, accepted the cycle after
    tbl_len = 7'd0; start0 = 1'b1; start2 = 1'b1;
    step();
    chk("len0_dut0", 96'({busy0, done0, wren0, rden0, hold0}), 96'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk("len0_dut2", 96'({busy2, done2, wren2, rden2, hold2}), 96'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    tbl_len = 7'd3;
    step();
    chk("b2b_ignored0", 96'({busy0, done0, wren0}), 96'(0));
    chk("b2b_ignored2", 96'({busy2, done2, wren2}), 96'(0));
    step();
    start0 = 1'b0; start2 = 1'b0;
    chk("b2b_accept0", 96'({busy0, wren0, addr0, wdata0}), 96'({1'b1, 1'b1, ea[0], ed[0]}));
    chk("b2b_accept2", 96'({busy2, wren2, addr2, wdata2}), 96'({1'b1, 1'b1, ea[0], ed[0]}));
    wait_idle("b2b_idle");

    // Over-long length clamps to DEPTH; a table write during the replay is dropped
    tbl_len = 7'd65; start0 = 1'b1;
    step();
    start0 = 1'b0;
    cnt = 0; done_cyc = 0; last_addr = '0;
    for (int c = 1; c <= 2000; c++) begin
      if (wren0) begin
        cnt++;
        last_addr = addr0;
      end
      if (done0) begin
        done_cyc = c;
        break;
      end
      tbl_wren0 = (c == 10); tbl_idx = 6'd0; tbl_addr = 32'hBAD; tbl_wdata = 32'hBAD;
      step();
    end
    tbl_wren0 = 1'b0;
    chk("depth_wr_count", 96'(cnt), 96'(64));
    chk("depth_last_addr", 96'(last_addr), 96'(ea[63]));
    chk("depth_done_seen", 96'(done_cyc != 0), 96'(1));
`ifndef RULE_READBACK_EN
    chk("depth_done_cycle", 96'(done_cyc), 96'(65));
`endif
    wait_idle("depth_idle");

    // Reset in the middle of a replay, then replay from entry 0 with the retained table
    tbl_len = 7'd3; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("rst_first_wr", 96'({wren0, addr0, wdata0}), 96'({1'b1, ea[0], ed[0]}));
    step();
`ifndef RULE_READBACK_EN
    chk("rst_second_wr", 96'({wren0, addr0, wdata0}), 96'({1'b1, ea[1], ed[1]}));
`endif
    rst_n = 1'b0;
    step();
    chk("rst_outs", 96'({busy0, hold0, done0, err0, erridx0, wren0, rden0, addr0, wdata0}), 96'(0));
    rst_n = 1'b1;
    step();
    chk("rst_idle", 96'({busy0, hold0, done0, wren0, rden0}), 96'(0));
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("rst_replay", 96'({busy0, wren0, addr0, wdata0}), 96'({1'b1, 1'b1, ea[0], ed[0]}));
    wait_idle("rst_replay_idle");

`ifdef RULE_READBACK_EN
    // Read-back with data 2 cycles after rden; entry 1 returns bad data
    tbl_len = 7'd3; start0 = 1'b1;
    step();
    start0 = 1'b0;
    cnt = 0; done_cyc = 0; pend = -1; pdata = '0;
    for (int c = 1; c <= 200; c++) begin
      if (wren0) begin
        chk($sformatf("rb_wr%0d_bus", cnt), 96'({addr0, wdata0}), 96'({ea[cnt], ed[cnt]}));
        cnt++;
      end
      if (rden0) begin
        wr_k = cnt - 1;
        chk($sformatf("rb_rd%0d_addr", wr_k), 96'(addr0), 96'(ea[wr_k]));
        pend = c + 2;
        pdata = (wr_k == 1) ? 32'hDEAD : ed[wr_k];
      end
      if (done0) begin
        done_cyc = c;
        break;
      end
      rvalid0 = (c == pend);
      rdata0 = (c == pend) ? pdata : 32'd0;
      step();
    end
    rvalid0 = 1'b0;
    chk("rb_wr_count", 96'(cnt), 96'(3));
    chk("rb_done_cycle", 96'(done_cyc), 96'(13));
    chk("rb_err", 96'({err0, erridx0}), 96'({1'b1, 6'd1}));
    step();
    chk("rb_err_sticky", 96'({busy0, err0, erridx0}), 96'({1'b0, 1'b1, 6'd1}));

    // Read-back where valid never arrives: every entry times out
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("tmo_err_cleared", 96'({err0, erridx0, wren0}), 96'({1'b0, 6'd0, 1'b1}));
    cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      if (wren0) cnt++;
      if (done0) begin
        done_cyc = c;
        break;
      end
      step();
    end
    chk("tmo_wr_count", 96'(cnt), 96'(3));
    chk("tmo_done_cycle", 96'(done_cyc), 96'(55));
    chk("tmo_err", 96'({err0, erridx0}), 96'({1'b1, 6'd0}));
    wait_idle("tmo_idle");
`else
    chk("norb_err_tied", 96'({err0, erridx0, err2, erridx2, rden0, rden2}), 96'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
